// File: rtl/neuron_pkg.sv
// Shared types and default widths for the spike-rate decoder.
// State enum and the default CNT_W, WIN_W and ISI_W constants.
package neuron_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 10;
  localparam int ISI_W_DEF = 12;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and sticky overflow flag.
// The o_* outputs are the values the counter takes on the next edge.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_nxt,
  output logic         o_sat_nxt
);

  logic [W-1:0] r_cnt;
  logic         r_sat;
  logic         w_max;

  assign w_max     = &r_cnt;
  assign o_nxt     = (i_inc && !w_max) ? r_cnt + W'(1) : r_cnt;
  assign o_sat_nxt = r_sat | (i_inc & w_max);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= o_nxt;
      r_sat <= o_sat_nxt;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder with a valid/ready result register.
// Define SPIKE_ISI_EN to add the inter-spike-interval output isi_out.
module spike_rate_decoder
  import neuron_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int ISI_W = ISI_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] win_len,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [CNT_W-1:0] rate_data,
  output logic             rate_sat,
  output logic             drop_flag
`ifdef SPIKE_ISI_EN
  ,
  output logic [ISI_W-1:0] isi_out
`endif
);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIN_W-1:0] r_win_cnt;
  logic             w_cnt_en;
  logic             w_close;
  logic             w_load;
  logic             w_xfer;
  logic             w_spk_clr;
  logic             w_spk_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sat_nxt;

  logic             r_valid;
  logic [CNT_W-1:0] r_data;
  logic             r_sat;
  logic             r_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (ena)  w_state_nxt = COUNT;
      COUNT: if (!ena) w_state_nxt = IDLE;
    endcase
  end

  assign w_cnt_en  = (r_state == COUNT) && ena;
  assign w_close   = w_cnt_en && (r_win_cnt == '0);
  assign w_load    = ((r_state == IDLE) && ena) || w_close;
  assign w_xfer    = r_valid && rate_ready;
  // Counter idles at zero outside a live window, so aborts discard it.
  assign w_spk_clr = !w_cnt_en || w_close;
  assign w_spk_inc = w_cnt_en && spike_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt <= '0;
    end else if (w_load) begin
      r_win_cnt <= win_len;
    end else if (w_cnt_en) begin
      r_win_cnt <= r_win_cnt - WIN_W'(1);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_spk_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_spk_clr),
    .i_inc     (w_spk_inc),
    .o_nxt     (w_cnt_nxt),
    .o_sat_nxt (w_sat_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sat   <= 1'b0;
      r_drop  <= 1'b0;
    end else if (w_close && (!r_valid || w_xfer)) begin
      r_valid <= 1'b1;
      r_data  <= w_cnt_nxt;
      r_sat   <= w_sat_nxt;
    end else begin
      if (w_close) r_drop  <= 1'b1;
      if (w_xfer)  r_valid <= 1'b0;
    end
  end

  assign rate_valid = r_valid;
  assign rate_data  = r_data;
  assign rate_sat   = r_sat;
  assign drop_flag  = r_drop;

`ifdef SPIKE_ISI_EN
  logic             r_seen;
  logic [ISI_W-1:0] r_isi;
  logic [ISI_W-1:0] w_gap_nxt;
  logic             w_gap_sat;

  sat_counter #(
    .W (ISI_W)
  ) u_gap_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (spike_in),
    .i_inc     (1'b1),
    .o_nxt     (w_gap_nxt),
    .o_sat_nxt (w_gap_sat)
  );

  // Gap counts cycles after a spike, so the interval is gap + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen <= 1'b0;
      r_isi  <= '0;
    end else if (spike_in) begin
      r_seen <= 1'b1;
      if (r_seen) r_isi <= w_gap_nxt;
    end
  end

  assign isi_out = r_isi;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomised bench for spike_rate_decoder against a window/queue model.
// Build with SPIKE_ISI_EN defined to also check isi_out.
module tb_spike_rate_decoder;

  localparam int CW   = 8;
  localparam int WW   = 10;
  localparam int IW   = 12;
  localparam int CMAX = 255;
  localparam int IMAX = 4095;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          spike_in;
  logic [WW-1:0] win_len;
  logic          rate_ready;
  logic          rate_valid;
  logic [CW-1:0] rate_data;
  logic          rate_sat;
  logic          drop_flag;
`ifdef SPIKE_ISI_EN
  logic [IW-1:0] isi_out;
`endif

  always #5 clk = ~clk;

  spike_rate_decoder #(
    .CNT_W (CW),
    .WIN_W (WW),
    .ISI_W (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .spike_in   (spike_in),
    .win_len    (win_len),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .rate_data  (rate_data),
    .rate_sat   (rate_sat),
    .drop_flag  (drop_flag)
`ifdef SPIKE_ISI_EN
    ,
    .isi_out    (isi_out)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: a window is a span of len+1 enabled cycles; result is its spike total.
  bit     m_active = 0;
  int     m_len = 0;
  int     m_pos = 0;
  int     m_sum = 0;
  bit     m_valid = 0;
  int     m_data = 0;
  bit     m_sat = 0;
  bit     m_drop = 0;
  bit     m_seen = 0;
  int     m_isi = 0;
  longint m_t = 0;
  longint m_tlast = 0;

  always @(posedge clk) begin : model
    bit xfer;
    bit close;
    int res;
    bit rsat;
    close = 1'b0;
    res   = 0;
    rsat  = 1'b0;
    if (rst) begin
      m_active = 0; m_len = 0; m_pos = 0; m_sum = 0;
      m_valid = 0; m_data = 0; m_sat = 0; m_drop = 0;
      m_seen = 0; m_isi = 0;
    end else begin
      xfer = m_valid && rate_ready;
      if (!m_active) begin
        if (ena) begin
          m_active = 1; m_len = int'(win_len);
          m_pos = 0; m_sum = 0;
        end
      end else if (!ena) begin
        m_active = 0;
      end else begin
        m_sum += int'(spike_in);
        if (m_pos == m_len) begin
          close = 1'b1;
          res   = (m_sum > CMAX) ? CMAX : m_sum;
          rsat  = (m_sum > CMAX);
          m_pos = 0; m_sum = 0; m_len = int'(win_len);
        end else begin
          m_pos++;
        end
      end
      if (close && (!m_valid || xfer)) begin
        m_valid = 1; m_data = res; m_sat = rsat;
      end else begin
        if (close) m_drop = 1;
        if (xfer)  m_valid = 0;
      end
      if (spike_in) begin
        if (m_seen)
          m_isi = (m_t - m_tlast > IMAX) ? IMAX : int'(m_t - m_tlast);
        m_seen  = 1;
        m_tlast = m_t;
      end
    end
    m_t++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (rate_valid !== m_valid || rate_data !== m_data[CW-1:0] ||
          rate_sat !== m_sat || drop_flag !== m_drop
`ifdef SPIKE_ISI_EN
          || isi_out !== m_isi[IW-1:0]
`endif
         ) begin
        n_bad++;
        $display("FAIL cycle t=%0t: dut v=%b d=%0d s=%b drop=%b, model v=%b d=%0d s=%b drop=%b",
                 $time, rate_valid, rate_data, rate_sat, drop_flag,
                 m_valid, m_data, m_sat, m_drop);
      end
    end
  end

  task automatic step(input bit r, input bit e, input bit s,
                      input int len, input bit rdy);
    rst        = r;
    ena        = e;
    spike_in   = s;
    win_len    = len[WW-1:0];
    rate_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1; ena = 0; spike_in = 0; win_len = '0; rate_ready = 0;
    step(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    lit("reset_valid", int'(rate_valid), 0);
    lit("reset_data", int'(rate_data), 0);
    lit("reset_drop", int'(drop_flag), 0);

    // Spikes on window cycles 2,5,9 of a 10-cycle window
    step(0, 1, 0, 9, 1);
    for (int c = 0; c < 10; c++) begin
      step(0, 1, (c == 2 || c == 5 || c == 9), 9, 1);
      if (c == 8) lit("basic_not_early", int'(rate_valid), 0);
    end
    lit("basic_valid", int'(rate_valid), 1);
    lit("basic_data", int'(rate_data), 3);
    lit("basic_sat", int'(rate_sat), 0);
    step(0, 1, 0, 9, 1);
    lit("basic_one_cycle", int'(rate_valid), 0);

    // Saturation over a 300-cycle window
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 299, 1);
    for (int c = 0; c < 300; c++) step(0, 1, 1, 299, 1);
    lit("sat_data", int'(rate_data), 255);
    lit("sat_flag", int'(rate_sat), 1);

    // Back-pressure: later windows dropped, first result held
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 3, 0);
    for (int c = 0; c < 12; c++) step(0, 1, 1, 3, 0);
    lit("bp_valid", int'(rate_valid), 1);
    lit("bp_data", int'(rate_data), 4);
    lit("bp_drop", int'(drop_flag), 1);
    step(0, 1, 1, 3, 1);
    lit("bp_xfer", int'(rate_valid), 0);
    for (int c = 0; c < 3; c++) step(0, 1, 1, 3, 1);
    lit("bp_next_valid", int'(rate_valid), 1);
    lit("bp_next_data", int'(rate_data), 4);

    // Close coincides with transfer
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 3, 0);
    for (int c = 0; c < 4; c++) step(0, 1, 1, 3, 0);
    for (int c = 0; c < 4; c++) step(0, 1, (c < 2), 3, (c == 3));
    lit("cx_valid", int'(rate_valid), 1);
    lit("cx_data", int'(rate_data), 2);
    lit("cx_drop", int'(drop_flag), 0);

    // Abort at window cycle 4, then a full window
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 9, 1);
    for (int c = 0; c < 4; c++) step(0, 1, 1, 9, 1);
    step(0, 0, 1, 9, 1);
    lit("abort_none", int'(rate_valid), 0);
    step(0, 1, 0, 9, 1);
    for (int c = 0; c < 10; c++) begin
      step(0, 1, 1, 9, 1);
      if (c == 8) lit("abort_not_early", int'(rate_valid), 0);
    end
    lit("abort_full_data", int'(rate_data), 10);

    // Reset with a pending result
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 3, 0);
    for (int c = 0; c < 6; c++) step(0, 1, 1, 3, 0);
    lit("pre_rst_valid", int'(rate_valid), 1);
    step(1, 1, 1, 3, 0);
    lit("rst_valid", int'(rate_valid), 0);
    lit("rst_data", int'(rate_data), 0);
    lit("rst_sat", int'(rate_sat), 0);
    lit("rst_drop", int'(drop_flag), 0);
`ifdef SPIKE_ISI_EN
    lit("rst_isi", int'(isi_out), 0);
    step(0, 0, 1, 0, 0);
    for (int c = 0; c < 6; c++) step(0, 0, 0, 0, 0);
    lit("isi_first", int'(isi_out), 0);
    step(0, 0, 1, 0, 0);
    lit("isi_seven", int'(isi_out), 7);
`endif

    // Randomised segments
    for (int seg = 0; seg < 20; seg++) begin
      int base;
      int dens;
      int rdy_p;
      int eoff;
      base  = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 600)
                                          : $urandom_range(0, 15);
      dens  = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(0, 100);
      rdy_p = $urandom_range(0, 100);
      eoff  = ($urandom_range(0, 1) == 0) ? 0 : 2;
      for (int c = 0; c < 400; c++) begin
        int len;
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : base;
        step($urandom_range(0, 499) == 0,
             $urandom_range(0, 99) >= eoff,
             $urandom_range(0, 99) < dens,
             len,
             $urandom_range(0, 99) < rdy_p);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter CNT_W, default 8, spike-count width.
REQ-002 Parameter WIN_W, default 10, window-length field width.
REQ-003 Parameter ISI_W, default 12, inter-spike-interval width (used only when SPIKE_ISI_EN is defined).
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ena  in  1  high = windowed counting enabled.
REQ-007 spike_in  in  1  LIF neuron spike; each high cycle counts as one spike.
REQ-008 win_len  in  WIN_W  window length minus 1; sampled at window start only.
REQ-009 rate_valid  out  1  result register holds an unconsumed result.
REQ-010 rate_ready  in  1  consumer accepts the result when high with rate_valid.
REQ-011 rate_data  out  CNT_W  spike count of the completed window.
REQ-012 rate_sat  out  1  the count in rate_data saturated.
REQ-013 drop_flag  out  1  sticky; a completed window result was discarded.
REQ-014 isi_out  out  ISI_W  cycles between the last two spikes (present only with SPIKE_ISI_EN).

Function
REQ-015 FSM states: IDLE and COUNT; IDLE->COUNT when ena=1; COUNT->IDLE when ena=0.
REQ-016 On each IDLE->COUNT transition and on every window close, load win_cnt=win_len and spike count=0.
REQ-017 In COUNT, win_cnt decrements each cycle; the window closes in the cycle win_cnt==0, so a window spans exactly win_len+1 cycles.
REQ-018 The closing-cycle spike_in is included in the window result; the next window starts with no idle cycle between.
REQ-019 The count saturates at 2^CNT_W-1; rate_sat=1 when any spike arrived while at maximum.
REQ-020 The result is loaded into rate_data/rate_sat with rate_valid=1 on the edge after the closing cycle (latency 1).
REQ-021 Handshake: transfer occurs when rate_valid and rate_ready are both high; rate_valid clears on the next edge unless a new result loads on that same edge.
REQ-022 On close with the register full and rate_ready=0, the new result is discarded, the old result is held unchanged, and drop_flag is set.
REQ-023 Close coinciding with a transfer loads the new result, keeps rate_valid=1, and leaves drop_flag unchanged.
REQ-024 ena=0 mid-window aborts the window, discards the partial count, and leaves the result register and handshake unaffected.
REQ-025 rate_data, rate_sat, and rate_valid are stable while rate_valid=1 and rate_ready=0.

Reset
REQ-026 rst forces IDLE, win_cnt=0, count=0, rate_valid=0, rate_data=0, rate_sat=0, drop_flag=0, isi_out=0, gap counter=0, and clears the seen-spike flag.
REQ-027 rst has priority over all inputs, including mid-window and mid-handshake; a pending result is lost.

Configuration
REQ-028 Macro SPIKE_ISI_EN defined: a gap counter increments every cycle (saturating at 2^ISI_W-1) independent of ena.
REQ-029 With SPIKE_ISI_EN, on a spike after the first spike since reset, isi_out takes the gap value plus 1; the gap counter then restarts at 0.
REQ-030 With SPIKE_ISI_EN, isi_out stays 0 until the second spike after reset.
REQ-031 SPIKE_ISI_EN undefined: the isi_out port, the gap counter, and the seen-spike flag are absent; all other behaviour is identical.

Structure
REQ-032 The shared package neuron_pkg holds the FSM state enum (IDLE, COUNT) and the default CNT_W, WIN_W, and ISI_W constants.
REQ-033 A single sub-module sat_counter (parameterised width, clear, increment, saturate flag) is used for the spike count and for the gap counter.

Verification
REQ-034 ena=1, win_len=9, spikes on window cycles 2,5,9, rate_ready=1 -> rate_valid for 1 cycle after cycle 9, with rate_data=3, rate_sat=0.
REQ-035 win_len=299, spike_in held high -> rate_data=255, rate_sat=1.
REQ-036 win_len=3, rate_ready=0 for 12 cycles -> first result (count 4) held, drop_flag=1; on rate_ready=1 one transfer occurs, then the next window's result.
REQ-037 win_len=3, close on the same edge as a transfer -> rate_valid stays 1, rate_data is the new count, drop_flag=0.
REQ-038 ena low at window cycle 4 of win_len=9 then high -> no result for the aborted window; next result covers a full 10 cycles.
REQ-039 rst pulse mid-window with a pending result -> all outputs 0 next cycle; with SPIKE_ISI_EN, spikes 7 cycles apart after reset -> isi_out=7.
